alu_pipe: RTL

- Parametrised, pipelined successor to the 8-bit single-cycle ALU.
- Generalised to WIDTH bits, with valid/ready handshakes on input and output, and a full flag set (carry, zero, negative, overflow).
- Adds a sticky carry for multi-word add (ADDC) and a completed-operation counter.
- Sits between an operand issue unit and a result sink; the directed testvector bench drives it through the handshake.

---
 rtl/alu_pkg.sv | 46 ++++
 rtl/alu_core.sv | 101 ++++++++++
 rtl/alu_pipe.sv | 119 +++++++++++
 3 files changed

// File: rtl/alu_pkg.sv
// -----------------------------------------------------------------------------
// alu_pkg
// Shared types and constants for the pipelined ALU.
//   alu_op_e    : 4-bit opcode encoding used on ALU_Sel
//   alu_flags_t : {carry, zero, negative, overflow} flag bundle
//   OP_W        : opcode width
//   SCARRY_OPS  : one bit per opcode; set where the op writes the sticky carry
// -----------------------------------------------------------------------------
package alu_pkg;

    localparam int OP_W = 4;

    typedef enum logic [OP_W-1:0] {
        OP_ADD  = 4'h0,
        OP_SUB  = 4'h1,
        OP_MUL  = 4'h2,
        OP_ADDC = 4'h3,
        OP_SHL  = 4'h4,
        OP_SHR  = 4'h5,
        OP_ROL  = 4'h6,
        OP_ROR  = 4'h7,
        OP_AND  = 4'h8,
        OP_OR   = 4'h9,
        OP_XOR  = 4'hA,
        OP_NOR  = 4'hB,
        OP_NAND = 4'hC,
        OP_XNOR = 4'hD,
        OP_GT   = 4'hE,
        OP_EQ   = 4'hF
    } alu_op_e;

    typedef struct packed {
        logic carry;
        logic zero;
        logic negative;
        logic overflow;
    } alu_flags_t;

    // ADD, SUB, MUL, ADDC, SHL, SHR
    localparam logic [15:0] SCARRY_OPS = 16'h003F;

    function automatic logic updates_sticky(input alu_op_e op);
        return SCARRY_OPS[op];
    endfunction

endpackage

// File: rtl/alu_core.sv
// -----------------------------------------------------------------------------
// alu_core
// Purely combinational WIDTH-bit ALU datapath with full flag generation.
//   A, B      : operands
//   op        : opcode (alu_op_e)
//   carry_in  : carry used by ADDC only
//   result    : WIDTH-bit result
//   flags     : carry / zero / negative / overflow for this result
// -----------------------------------------------------------------------------
module alu_core
    import alu_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  alu_op_e          op,
    input  logic             carry_in,
    output logic [WIDTH-1:0] result,
    output alu_flags_t       flags
);

    localparam int MSB = WIDTH - 1;

    logic [WIDTH:0]       sum_ext;
    logic [2*WIDTH-1:0]   prod;
    logic [WIDTH-1:0]     res;
    logic                 carry;
    logic                 ovf;

    always_comb begin
        sum_ext = '0;
        prod    = '0;
        res     = '0;
        carry   = 1'b0;

        case (op)
            OP_ADD: begin
                sum_ext = {1'b0, A} + {1'b0, B};
                res     = sum_ext[WIDTH-1:0];
                carry   = sum_ext[WIDTH];
            end
            OP_SUB: begin
                // the extended difference goes negative exactly when A < B
                sum_ext = {1'b0, A} - {1'b0, B};
                res     = sum_ext[WIDTH-1:0];
                carry   = sum_ext[WIDTH];
            end
            OP_MUL: begin
                prod  = {{WIDTH{1'b0}}, A} * {{WIDTH{1'b0}}, B};
                res   = prod[WIDTH-1:0];
                carry = |prod[2*WIDTH-1:WIDTH];
            end
            OP_ADDC: begin
                sum_ext = {1'b0, A} + {1'b0, B} + {{WIDTH{1'b0}}, carry_in};
                res     = sum_ext[WIDTH-1:0];
                carry   = sum_ext[WIDTH];
            end
            OP_SHL: begin
                res   = {A[MSB-1:0], 1'b0};
                carry = A[MSB];
            end
            OP_SHR: begin
                res   = {1'b0, A[MSB:1]};
                carry = A[0];
            end
            OP_ROL:  res = {A[MSB-1:0], A[MSB]};
            OP_ROR:  res = {A[0], A[MSB:1]};
            OP_AND:  res = A & B;
            OP_OR:   res = A | B;
            OP_XOR:  res = A ^ B;
            OP_NOR:  res = ~(A | B);
            OP_NAND: res = ~(A & B);
            OP_XNOR: res = ~(A ^ B);
            OP_GT:   res = {{(WIDTH-1){1'b0}}, (A > B)};
            OP_EQ:   res = {{(WIDTH-1){1'b0}}, (A == B)};
            default: res = '0;
        endcase
    end

    // Signed overflow from operand/result sign bits; only the add/sub family
    // can overflow in a two's-complement sense.
    always_comb begin
        ovf = 1'b0;
        case (op)
            OP_ADD, OP_ADDC: ovf = (A[MSB] == B[MSB]) && (res[MSB] != A[MSB]);
            OP_SUB:          ovf = (A[MSB] != B[MSB]) && (res[MSB] != A[MSB]);
            default:         ovf = 1'b0;
        endcase
    end

    always_comb begin
        result         = res;
        flags          = '0;
        flags.carry    = carry;
        flags.zero     = (res == '0);
        flags.negative = res[MSB];
        flags.overflow = ovf;
    end

endmodule

// File: rtl/alu_pipe.sv
// -----------------------------------------------------------------------------
// alu_pipe
// Two-stage pipelined ALU with valid/ready handshakes, sticky carry for
// multi-word adds, and a count of consumed results.
//   clock, reset        : clock, synchronous active-high reset
//   in_valid / in_ready : operation handshake for A, B, ALU_Sel
//   flag_clr            : clears the sticky carry
//   out_valid/out_ready : result handshake
//   ALU_Out + flags     : registered result, CarryOut, Zero, Negative, Overflow
//   ops_done            : results consumed, wraps modulo 2^CNT_W
// -----------------------------------------------------------------------------
module alu_pipe
    import alu_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int CNT_W = 16
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic [OP_W-1:0]  ALU_Sel,
    input  logic             flag_clr,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] ALU_Out,
    output logic             CarryOut,
    output logic             Zero,
    output logic             Negative,
    output logic             Overflow,
    output logic [CNT_W-1:0] ops_done
);

    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    logic             s1_valid;
    logic [WIDTH-1:0] s1_a;
    logic [WIDTH-1:0] s1_b;
    alu_op_e          s1_op;
    logic             sticky;

    logic             s2_load;
    logic             accept;
    logic             core_cin;
    logic [WIDTH-1:0] core_result;
    alu_flags_t       core_flags;

    // S2 can take a new entry when it is empty or its current result leaves
    // this cycle. in_ready depends only on registered state and out_ready.
    assign s2_load  = !out_valid || out_ready;
    assign in_ready = !s1_valid || s2_load;
    assign accept   = in_valid && in_ready;

    // The sticky register already holds the carry of the op directly ahead
    // (written when that op loaded S2), so back-to-back ADD/ADDC chains are
    // exact. A clear in this same cycle takes precedence for the ADDC too.
    assign core_cin = sticky && !flag_clr;

    alu_core #(
        .WIDTH (WIDTH)
    ) u_core (
        .A        (s1_a),
        .B        (s1_b),
        .op       (s1_op),
        .carry_in (core_cin),
        .result   (core_result),
        .flags    (core_flags)
    );

    always_ff @(posedge clock) begin
        if (reset) begin
            s1_valid  <= 1'b0;
            s1_a      <= '0;
            s1_b      <= '0;
            s1_op     <= OP_ADD;
            sticky    <= 1'b0;
            out_valid <= 1'b0;
            ALU_Out   <= '0;
            CarryOut  <= 1'b0;
            Zero      <= 1'b0;
            Negative  <= 1'b0;
            Overflow  <= 1'b0;
            ops_done  <= '0;
        end else begin
            if (accept) begin
                s1_valid <= 1'b1;
                s1_a     <= A;
                s1_b     <= B;
                s1_op    <= alu_op_e'(ALU_Sel);
            end else if (s2_load) begin
                s1_valid <= 1'b0;
            end

            if (s2_load) begin
                out_valid <= s1_valid;
                if (s1_valid) begin
                    ALU_Out  <= core_result;
                    CarryOut <= core_flags.carry;
                    Zero     <= core_flags.zero;
                    Negative <= core_flags.negative;
                    Overflow <= core_flags.overflow;
                end
            end

            if (flag_clr) begin
                sticky <= 1'b0;
            end else if (s2_load && s1_valid && updates_sticky(s1_op)) begin
                sticky <= core_flags.carry;
            end

            if (out_valid && out_ready) begin
                ops_done <= ops_done + CNT_ONE;
            end
        end
    end

endmodule
